// File: rtl/decode_execute_buffer_if.sv
// Decode->execute bundle: control-unit side (master) drives *D, stall and flush;
// the buffer (slave) returns the registered *E copies and sequencer status.
`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`endif

interface decode_execute_buffer_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 32,
    parameter int REG_AW = 3
);
    logic              stall, flush;
    logic [9:0]        ctrlD, ctrlE;
    logic [4:0]        aluSignalsD, aluSignalsE;
    logic              stD, sstD, shiftD, stE, sstE, shiftE;
    logic [1:0]        flushNumD, enablePushOrPopD, firstTimeCallD, firstTimeRETD;
    logic [1:0]        flushNumE, enablePushOrPopE, firstTimeCallE, firstTimeRETE;
    logic [DATA_W-1:0] rsrcDataD, rdstDataD, immD, rsrcDataE, rdstDataE, immE;
    logic [REG_AW-1:0] rsrcAddrD, rdstAddrD, rsrcAddrE, rdstAddrE;
    logic [PC_W-1:0]   pcD, pcE;
    logic              validE, seqBusy, seqErr;
    logic [15:0]       bubbleCount;

    modport master (
        output stall, flush, ctrlD, aluSignalsD, stD, sstD, shiftD, flushNumD,
               enablePushOrPopD, firstTimeCallD, firstTimeRETD, rsrcDataD,
               rdstDataD, immD, rsrcAddrD, rdstAddrD, pcD,
        input  ctrlE, aluSignalsE, stE, sstE, shiftE, flushNumE, enablePushOrPopE,
               firstTimeCallE, firstTimeRETE, rsrcDataE, rdstDataE, immE,
               rsrcAddrE, rdstAddrE, pcE, validE, seqBusy, seqErr, bubbleCount
    );

    modport slave (
        input  stall, flush, ctrlD, aluSignalsD, stD, sstD, shiftD, flushNumD,
               enablePushOrPopD, firstTimeCallD, firstTimeRETD, rsrcDataD,
               rdstDataD, immD, rsrcAddrD, rdstAddrD, pcD,
        output ctrlE, aluSignalsE, stE, sstE, shiftE, flushNumE, enablePushOrPopE,
               firstTimeCallE, firstTimeRETE, rsrcDataE, rdstDataE, immE,
               rsrcAddrE, rdstAddrE, pcE, validE, seqBusy, seqErr, bubbleCount
    );
endinterface

// File: rtl/decode_execute_buffer.sv
// Decode/execute pipeline register with a two-cycle instruction sequencer (LDM/CALL/RET).
// Optional bubble counter enabled by defining BUBBLE_COUNT_EN.
module decode_execute_buffer #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 32,
    parameter int REG_AW = 3
) (
    input logic                   clk,
    input logic                   rst,
    decode_execute_buffer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LDM2, CALL2, RET2, DRAIN} seq_t;

    seq_t              r_state, w_state_nxt, w_entry;
    logic              w_err_set, w_valid;
    logic [9:0]        r_ctrl;
    logic [4:0]        r_alu;
    logic              r_st, r_sst, r_shift, r_valid, r_err;
    logic [1:0]        r_flush_num, r_epp, r_fcall, r_fret;
    logic [DATA_W-1:0] r_rsrc_data, r_rdst_data, r_imm;
    logic [REG_AW-1:0] r_rsrc_addr, r_rdst_addr;
    logic [PC_W-1:0]   r_pc;

    assign w_valid = !(bus.ctrlD == 10'd0 && bus.aluSignalsD == `ALU_NOP &&
                       bus.enablePushOrPopD == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl      <= '0;
            r_alu       <= `ALU_NOP;
            r_st        <= 1'b0;
            r_sst       <= 1'b0;
            r_shift     <= 1'b0;
            r_flush_num <= '0;
            r_epp       <= '0;
            r_fcall     <= '0;
            r_fret      <= '0;
            r_rsrc_data <= '0;
            r_rdst_data <= '0;
            r_imm       <= '0;
            r_rsrc_addr <= '0;
            r_rdst_addr <= '0;
            r_pc        <= '0;
            r_valid     <= 1'b0;
        end else if (bus.flush) begin
            // Bubble, but keep the control unit's flush countdown alive
            r_ctrl      <= '0;
            r_alu       <= `ALU_NOP;
            r_st        <= 1'b0;
            r_sst       <= 1'b0;
            r_shift     <= 1'b0;
            r_flush_num <= bus.flushNumD;
            r_epp       <= '0;
            r_fcall     <= '0;
            r_fret      <= '0;
            r_valid     <= 1'b0;
        end else if (!bus.stall) begin
            r_ctrl      <= bus.ctrlD;
            r_alu       <= bus.aluSignalsD;
            r_st        <= bus.stD;
            r_sst       <= bus.sstD;
            r_shift     <= bus.shiftD;
            r_flush_num <= bus.flushNumD;
            r_epp       <= bus.enablePushOrPopD;
            r_fcall     <= bus.firstTimeCallD;
            r_fret      <= bus.firstTimeRETD;
            r_rsrc_data <= bus.rsrcDataD;
            r_rdst_data <= bus.rdstDataD;
            r_imm       <= bus.immD;
            r_rsrc_addr <= bus.rsrcAddrD;
            r_rdst_addr <= bus.rdstAddrD;
            r_pc        <= bus.pcD;
            r_valid     <= w_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)            r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
    end

    always_comb begin
        w_entry = IDLE;
        if (bus.stD && bus.sstD)               w_entry = LDM2;
        else if (bus.firstTimeCallD == 2'b11)  w_entry = CALL2;
        else if (bus.firstTimeRETD == 2'b11)   w_entry = RET2;
    end

    // A broken sequence still treats its load as a fresh IDLE entry
    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        if (bus.flush) begin
            w_state_nxt = IDLE;
        end else if (!bus.stall) begin
            case (r_state)
                IDLE:  w_state_nxt = w_entry;
                LDM2:  if ({bus.stD, bus.sstD} == 2'b10) w_state_nxt = IDLE;
                       else begin w_err_set = 1'b1; w_state_nxt = w_entry; end
                CALL2: if (bus.firstTimeCallD == 2'b01) w_state_nxt = IDLE;
                       else begin w_err_set = 1'b1; w_state_nxt = w_entry; end
                RET2:  if (bus.firstTimeRETD == 2'b01) w_state_nxt = DRAIN;
                       else begin w_err_set = 1'b1; w_state_nxt = w_entry; end
                DRAIN: if (bus.flushNumD == 2'd0) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

`ifdef BUBBLE_COUNT_EN
    logic [15:0] r_bubble;
    always_ff @(posedge clk) begin
        if (rst)
            r_bubble <= '0;
        else if ((bus.flush || (!bus.stall && !w_valid)) && r_bubble != 16'hFFFF)
            r_bubble <= r_bubble + 16'd1;
    end
    assign bus.bubbleCount = r_bubble;
`else
    assign bus.bubbleCount = 16'h0000;
`endif

    assign bus.ctrlE            = r_ctrl;
    assign bus.aluSignalsE      = r_alu;
    assign bus.stE              = r_st;
    assign bus.sstE             = r_sst;
    assign bus.shiftE           = r_shift;
    assign bus.flushNumE        = r_flush_num;
    assign bus.enablePushOrPopE = r_epp;
    assign bus.firstTimeCallE   = r_fcall;
    assign bus.firstTimeRETE    = r_fret;
    assign bus.rsrcDataE        = r_rsrc_data;
    assign bus.rdstDataE        = r_rdst_data;
    assign bus.immE             = r_imm;
    assign bus.rsrcAddrE        = r_rsrc_addr;
    assign bus.rdstAddrE        = r_rdst_addr;
    assign bus.pcE              = r_pc;
    assign bus.validE           = r_valid;
    assign bus.seqBusy          = (r_state != IDLE);
    assign bus.seqErr           = r_err;
endmodule

// File: tb/tb_decode_execute_buffer.sv
// Bench for decode_execute_buffer: directed test-plan steps then random traffic,
// compared against a behavioural model of the register/sequencer rules.
module tb_decode_execute_buffer;
    localparam int DATA_W = 16;
    localparam int PC_W   = 32;
    localparam int REG_AW = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    decode_execute_buffer_if #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) bus ();
    decode_execute_buffer #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Expected model state
    logic [111:0] m_bundle;
    logic         m_valid, m_err;
    logic [15:0]  m_cnt;
    string        m_need;

    function automatic logic [111:0] reset_bundle();
        logic [111:0] b;
        b = '0;
        b[101:97] = `ALU_NOP;
        return b;
    endfunction

    function automatic logic [111:0] d_bundle();
        return {bus.ctrlD, bus.aluSignalsD, bus.stD, bus.sstD, bus.shiftD, bus.flushNumD,
                bus.enablePushOrPopD, bus.firstTimeCallD, bus.firstTimeRETD, bus.rsrcDataD,
                bus.rdstDataD, bus.immD, bus.rsrcAddrD, bus.rdstAddrD, bus.pcD};
    endfunction

    function automatic logic [111:0] e_bundle();
        return {bus.ctrlE, bus.aluSignalsE, bus.stE, bus.sstE, bus.shiftE, bus.flushNumE,
                bus.enablePushOrPopE, bus.firstTimeCallE, bus.firstTimeRETE, bus.rsrcDataE,
                bus.rdstDataE, bus.immE, bus.rsrcAddrE, bus.rdstAddrE, bus.pcE};
    endfunction

    function automatic string entry_of();
        if (bus.stD && bus.sstD)              return "ldm";
        if (bus.firstTimeCallD == 2'b11)      return "call";
        if (bus.firstTimeRETD == 2'b11)       return "ret";
        return "";
    endfunction

    function automatic void bump();
`ifdef BUBBLE_COUNT_EN
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    endfunction

    task automatic model_edge();
        logic real_instr;
        if (rst) begin
            m_bundle = reset_bundle();
            m_valid = 0; m_err = 0; m_cnt = 0; m_need = "";
        end else if (bus.flush) begin
            // Keep data/addr/pc bits (lower 86), clear control, reload flushNum
            m_bundle[111:86] = '0;
            m_bundle[101:97] = `ALU_NOP;
            m_bundle[93:92]  = bus.flushNumD;
            m_valid = 0; m_need = "";
            bump();
        end else if (!bus.stall) begin
            real_instr = (bus.ctrlD != 0) || (bus.aluSignalsD != `ALU_NOP) ||
                         (bus.enablePushOrPopD != 0);
            m_bundle = d_bundle();
            m_valid = real_instr;
            if (!real_instr) bump();
            if (m_need == "ldm") begin
                if ({bus.stD, bus.sstD} == 2'b10) m_need = "";
                else begin m_err = 1; m_need = entry_of(); end
            end else if (m_need == "call") begin
                if (bus.firstTimeCallD == 2'b01) m_need = "";
                else begin m_err = 1; m_need = entry_of(); end
            end else if (m_need == "ret") begin
                if (bus.firstTimeRETD == 2'b01) m_need = "drain";
                else begin m_err = 1; m_need = entry_of(); end
            end else if (m_need == "drain") begin
                if (bus.flushNumD == 0) m_need = "";
            end else begin
                m_need = entry_of();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("bundleE", {16'h0, e_bundle()}, {16'h0, m_bundle});
        chk("validE", {127'h0, bus.validE}, {127'h0, m_valid});
        chk("seqBusy", {127'h0, bus.seqBusy}, {127'h0, (m_need != "")});
        chk("seqErr", {127'h0, bus.seqErr}, {127'h0, m_err});
        chk("bubbleCount", {112'h0, bus.bubbleCount}, {112'h0, m_cnt});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic clr_d();
        rst = 0; bus.stall = 0; bus.flush = 0;
        bus.ctrlD = 0; bus.aluSignalsD = `ALU_NOP; bus.stD = 0; bus.sstD = 0; bus.shiftD = 0;
        bus.flushNumD = 0; bus.enablePushOrPopD = 0; bus.firstTimeCallD = 0;
        bus.firstTimeRETD = 0; bus.rsrcDataD = 0; bus.rdstDataD = 0; bus.immD = 0;
        bus.rsrcAddrD = 0; bus.rdstAddrD = 0; bus.pcD = 0;
    endtask

    // Random instruction payload with all sequence markers cleared
    task automatic rand_d();
        clr_d();
        bus.ctrlD = 10'($urandom); bus.aluSignalsD = 5'($urandom); bus.shiftD = 1'($urandom);
        bus.rsrcDataD = 16'($urandom); bus.rdstDataD = 16'($urandom); bus.immD = 16'($urandom);
        bus.rsrcAddrD = 3'($urandom); bus.rdstAddrD = 3'($urandom); bus.pcD = $urandom;
    endtask

    initial begin
        int busy_cycles;
        clr_d();
        m_bundle = reset_bundle(); m_valid = 0; m_err = 0; m_cnt = 0; m_need = "";

        // Reset then idle
        rand_d(); rst = 1; step(); step();
        chk("rst_alu", {123'h0, bus.aluSignalsE}, {123'h0, `ALU_NOP});
        chk("rst_busy", {127'h0, bus.seqBusy}, 128'h0);

        // LDM pair
        rand_d(); bus.stD = 1; bus.sstD = 1; step();
        chk("ldm_busy", {127'h0, bus.seqBusy}, 128'h1);
        rand_d(); bus.stD = 1; bus.immD = 16'h1234; step();
        chk("ldm_imm", {112'h0, bus.immE}, 128'h1234);
        chk("ldm_idle", {126'h0, bus.seqBusy, bus.seqErr}, 128'h0);

        // Broken CALL, sticky error
        rand_d(); bus.firstTimeCallD = 2'b11; step();
        rand_d(); step();
        chk("call_err", {127'h0, bus.seqErr}, 128'h1);
        for (int i = 0; i < 5; i++) begin rand_d(); step(); end
        chk("call_err_sticky", {127'h0, bus.seqErr}, 128'h1);

        // RET with drain
        clr_d(); rst = 1; step();
        rand_d(); bus.firstTimeRETD = 2'b11; step();
        busy_cycles = bus.seqBusy;
        rand_d(); bus.firstTimeRETD = 2'b01; bus.flushNumD = 2; step();
        busy_cycles += bus.seqBusy;
        rand_d(); bus.flushNumD = 1; step();
        busy_cycles += bus.seqBusy;
        rand_d(); bus.flushNumD = 0; step();
        busy_cycles += bus.seqBusy;
        chk("ret_busy_cycles", 128'(busy_cycles), 128'd3);

        // Stall in CALL2 then flush
        rand_d(); bus.firstTimeCallD = 2'b11; step();
        for (int i = 0; i < 3; i++) begin rand_d(); bus.stall = 1; step(); end
        chk("stall_hold_busy", {127'h0, bus.seqBusy}, 128'h1);
        rand_d(); bus.stall = 1; bus.flush = 1; bus.flushNumD = 2; step();
        chk("flush_ctrl", {118'h0, bus.ctrlE}, 128'h0);
        chk("flush_num", {126'h0, bus.flushNumE}, 128'h2);
        chk("flush_idle", {126'h0, bus.seqBusy, bus.seqErr}, 128'h0);

        // Bubble counter: 4 flushes, 2 NOP loads, 1 stall
        clr_d(); rst = 1; step();
        for (int i = 0; i < 4; i++) begin rand_d(); bus.flush = 1; step(); end
        for (int i = 0; i < 2; i++) begin clr_d(); step(); end
        rand_d(); bus.stall = 1; step();
`ifdef BUBBLE_COUNT_EN
        chk("bubble_count", {112'h0, bus.bubbleCount}, 128'd6);
`else
        chk("bubble_count", {112'h0, bus.bubbleCount}, 128'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_d();
            if ($urandom_range(0, 3) == 0) bus.aluSignalsD = `ALU_NOP;
            if ($urandom_range(0, 3) == 0) bus.ctrlD = 0;
            bus.enablePushOrPopD = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            bus.stD = 1'($urandom); bus.sstD = 1'($urandom);
            bus.firstTimeCallD = 2'($urandom); bus.firstTimeRETD = 2'($urandom);
            bus.flushNumD = 2'($urandom);
            bus.stall = ($urandom_range(0, 5) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
